// File: rtl/peripheral_uart_rfifo_gen_wb.sv
// UART receive FIFO with per-entry error flags, sticky overrun and RX trigger level.
// First-word fall-through: data_out always shows the head entry, zero while empty.
module peripheral_uart_rfifo_gen_wb #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  input  logic                    fifo_reset,
  input  logic                    reset_status,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W+ERR_W-1:0] data_in,
  input  logic [1:0]              trig_level,
  output logic [DATA_W+ERR_W-1:0] data_out,
  output logic [CNT_W-1:0]        count,
  output logic                    empty,
  output logic                    full,
  output logic                    overrun,
  output logic [CNT_W-1:0]        err_count,
  output logic                    error_bit,
  output logic                    trigger
);

  localparam int ENT_W = DATA_W + ERR_W;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] threshold;
  logic             do_push;
  logic             do_pop;
  logic             in_err;
  logic             head_err;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign error_bit = (err_count != '0);
  assign trigger   = (count >= threshold);
  assign data_out  = empty ? '0 : mem[head];

  // A push while full only lands if a pop frees the head slot in the same cycle.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    in_err   = |data_in[ERR_W-1:0];
    head_err = |mem[head][ERR_W-1:0];
  end

  always_comb begin
    threshold = CNT_ONE;
    case (trig_level)
      2'd0: threshold = CNT_ONE;
      2'd1: threshold = CNT_W'(DEPTH / 4);
      2'd2: threshold = CNT_W'(DEPTH / 2);
      2'd3: threshold = CNT_W'(DEPTH - 2);
      default: threshold = CNT_ONE;
    endcase
  end

  // Storage is never reset; outputs are masked by the counters instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i || fifo_reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      case ({do_push && in_err, do_pop && head_err})
        2'b10:   err_count <= err_count + CNT_ONE;
        2'b01:   err_count <= err_count - CNT_ONE;
        default: err_count <= err_count;
      endcase
      // Clearing wins over a same-cycle lost character.
      if (reset_status)               overrun <= 1'b0;
      else if (push && full && !pop)  overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_peripheral_uart_rfifo_gen_wb.sv
// Self-checking bench for the UART RX FIFO: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_peripheral_uart_rfifo_gen_wb;

  localparam int DEPTH = 16;
  localparam int W     = 11;

  logic         clk = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         fifo_reset = 1'b0;
  logic         reset_status = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [1:0]   trig_level = 2'd0;
  logic [W-1:0] data_out;
  logic [4:0]   count;
  logic         empty;
  logic         full;
  logic         overrun;
  logic [4:0]   err_count;
  logic         error_bit;
  logic         trigger;

  int total = 0;
  int bad = 0;

  logic [W-1:0] model_q[$];
  logic         model_ovr = 1'b0;

  peripheral_uart_rfifo_gen_wb dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .fifo_reset(fifo_reset), .reset_status(reset_status),
    .push(push), .pop(pop), .data_in(data_in), .trig_level(trig_level),
    .data_out(data_out), .count(count), .empty(empty), .full(full), .overrun(overrun),
    .err_count(err_count), .error_bit(error_bit), .trigger(trigger)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_errs();
    int n = 0;
    foreach (model_q[i]) if (model_q[i][2:0] != 3'b000) n++;
    return n;
  endfunction

  function automatic int model_thr(input logic [1:0] tl);
    case (tl)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic check_all();
    int n = model_q.size();
    int e = model_errs();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("overrun", 32'(overrun), 32'(model_ovr));
    chk("err_count", 32'(err_count), 32'(e));
    chk("error_bit", 32'(error_bit), 32'(e != 0));
    chk("trigger", 32'(trigger), 32'(n >= model_thr(trig_level)));
    chk("data_out", 32'(data_out), (n == 0) ? 32'd0 : 32'(model_q[0]));
  endtask

  // One clock with the given controls held across the rising edge, then model update and check.
  task automatic step(input logic p, input logic q, input logic [W-1:0] d,
                      input logic fr, input logic rs, input logic rst);
    bit was_full;
    bit was_empty;
    push = p; pop = q; data_in = d; fifo_reset = fr; reset_status = rs; wb_rst_i = rst;
    @(posedge clk);
    #1;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (rst || fr) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      if (q && !was_empty) void'(model_q.pop_front());
      if (p && (!was_full || q)) model_q.push_back(d);
      if (rs) model_ovr = 1'b0;
      else if (p && was_full && !q) model_ovr = 1'b1;
    end
    push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0; wb_rst_i = 1'b0;
    check_all();
  endtask

  initial begin
    logic [W-1:0] head_before;

    // Reset
    step(0, 0, '0, 0, 0, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout", 32'(data_out), 32'd0);

    // In-order fill to full, then drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'(i << 3), 0, 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(data_out), 32'(i << 3));
      step(0, 1, '0, 0, 0, 0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(0, 1, '0, 0, 0, 0);

    // Overrun on push while full, then clear
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'((i + 1) << 3), 0, 0, 0);
    head_before = data_out;
    step(1, 0, 11'h7F8, 0, 0, 0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(data_out), 32'(head_before));
    step(0, 0, '0, 0, 0, 0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step(1, 0, 11'h123, 0, 1, 0);
    chk("ovr_clear_prio", 32'(overrun), 32'd0);

    // Push+pop while full: count holds, no overrun, pointers wrap
    for (int i = 0; i < 20; i++) step(1, 1, W'((8'hA0 + i) << 3), 0, 0, 0);
    chk("pp_full_cnt", 32'(count), 32'd16);
    chk("pp_full_ovr", 32'(overrun), 32'd0);

    // Flush
    step(1, 1, 11'h005, 1, 0, 0);
    chk("flush_cnt", 32'(count), 32'd0);

    // Error flag accounting
    step(1, 0, {8'h41, 3'b000}, 0, 0, 0);
    step(1, 0, {8'h42, 3'b010}, 0, 0, 0);
    step(1, 0, {8'h43, 3'b100}, 0, 0, 0);
    chk("err_two", 32'(err_count), 32'd2);
    step(0, 1, '0, 0, 0, 0);
    step(0, 1, '0, 0, 0, 0);
    chk("err_one", 32'(err_count), 32'd1);
    step(0, 1, '0, 0, 0, 0);
    chk("err_none", 32'(error_bit), 32'd0);

    // Push+pop while empty acts as push only
    step(1, 1, 11'h2A9, 0, 0, 0);
    chk("pp_empty_cnt", 32'(count), 32'd1);
    step(0, 1, '0, 0, 0, 0);

    // Trigger thresholds
    trig_level = 2'd1;
    for (int i = 0; i < 3; i++) step(1, 0, W'(i), 0, 0, 0);
    chk("trig_at3", 32'(trigger), 32'd0);
    step(1, 0, 11'h010, 0, 0, 0);
    chk("trig_at4", 32'(trigger), 32'd1);
    trig_level = 2'd3;
    for (int i = 0; i < 9; i++) step(1, 0, W'(i << 3), 0, 0, 0);
    chk("trig3_at13", 32'(trigger), 32'd0);
    step(1, 0, 11'h018, 0, 0, 0);
    chk("trig3_at14", 32'(trigger), 32'd1);

    // Reset mid-fill wins over push
    step(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, {8'(i), 3'b001}, 0, 0, 0);
    step(1, 0, 11'h7FF, 0, 0, 1);
    chk("midrst_cnt", 32'(count), 32'd0);
    chk("midrst_dout", 32'(data_out), 32'd0);
    chk("midrst_err", 32'(error_bit), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      trig_level = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), W'($urandom),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 199) < 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
